multi_cycle_controller: RTL and testbench

Multi-cycle control sequencer for the single-issue MIPS-subset core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the instruction fetch unit's `branch`, `jump` and `jumpReg` selects together with a one-cycle PC-update strobe. It also generates the register-file, ALU and data-memory controls, and stalls on data-memory handshakes. It sits between the instruction register and the datapath, and is the only source of PC-advance timing in the core.

---
 rtl/multi_cycle_controller.sv | 171 +++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS-subset core.
// Define MCC_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multi_cycle_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             pc_en,
    output logic             branch,
    output logic             jump,
    output logic             jump_reg,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic [2:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    state_e     state_q;
    logic [5:0] opcode_q;
    logic [5:0] funct_q;
`ifdef MCC_ILLEGAL_TRAP_EN
    logic       illegal_q;
`endif

    logic is_rtype, is_add, is_sub, is_slt, is_jr;
    logic is_lw, is_sw, is_j, is_bltz, is_alu;
    logic unused_instr;

    // Only opcode and funct fields steer control.
    assign unused_instr = ^instr[25:6];

    assign is_rtype = (opcode_q == 6'b000000);
    assign is_add   = is_rtype && (funct_q == 6'b100000);
    assign is_sub   = is_rtype && (funct_q == 6'b100010);
    assign is_slt   = is_rtype && (funct_q == 6'b101010);
    assign is_jr    = is_rtype && (funct_q == 6'b001000);
    assign is_alu   = is_add || is_sub || is_slt;
    assign is_lw    = (opcode_q == 6'b100011);
    assign is_sw    = (opcode_q == 6'b101011);
    assign is_j     = (opcode_q == 6'b000010);
    assign is_bltz  = (opcode_q == 6'b000001);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            opcode_q  <= '0;
            funct_q   <= '0;
            retired   <= '0;
`ifdef MCC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            if (pc_en) begin
                retired <= retired + CNT_W'(1);
            end
            case (state_q)
                StFetch: begin
                    opcode_q <= instr[31:26];
                    funct_q  <= instr[5:0];
                    state_q  <= StDecode;
                end
                StDecode: begin
                    if (is_j || is_jr || is_bltz) begin
                        state_q <= StFetch;
                    end else if (is_alu || is_lw || is_sw) begin
                        state_q <= StExec;
                    end else begin
`ifdef MCC_ILLEGAL_TRAP_EN
                        state_q   <= StTrap;
                        illegal_q <= 1'b1;
`else
                        state_q   <= StFetch;
`endif
                    end
                end
                StExec:  state_q <= is_alu ? StWb : StMem;
                StMem: begin
                    if (mem_ready) begin
                        state_q <= is_lw ? StWb : StFetch;
                    end
                end
                StWb:    state_q <= StFetch;
                StTrap:  state_q <= StTrap;
                default: state_q <= StFetch;
            endcase
        end
    end

`ifdef MCC_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign state = state_q;

    always_comb begin
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = 3'b000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            StFetch: ir_load = 1'b1;
            StDecode: begin
                if (is_j) begin
                    jump  = 1'b1;
                    pc_en = 1'b1;
                end else if (is_jr) begin
                    jump_reg = 1'b1;
                    pc_en    = 1'b1;
                end else if (is_bltz) begin
                    branch = 1'b1;
                    pc_en  = 1'b1;
                end else if (!(is_alu || is_lw || is_sw)) begin
`ifndef MCC_ILLEGAL_TRAP_EN
                    pc_en = 1'b1;
`endif
                end
            end
            StExec: begin
                if (is_alu) begin
                    reg_dst = 1'b1;
                    alu_op  = is_sub ? 3'b001 : (is_slt ? 3'b010 : 3'b000);
                end else begin
                    alu_src = 1'b1;
                end
            end
            StMem: begin
                alu_src   = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                // sw retires in the same cycle the memory accepts the write.
                pc_en     = is_sw && mem_ready;
            end
            StWb: begin
                reg_write  = 1'b1;
                pc_en      = 1'b1;
                mem_to_reg = is_lw;
                reg_dst    = is_alu;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Table-driven bench for multi_cycle_controller, plus reset-abort and counter-wrap sequences.
module tb_multi_cycle_controller;

    localparam int unsigned CW = 4;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_SUB  = 32'h0022_1822;
    localparam logic [31:0] I_SLT  = 32'h0022_182A;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_SW   = 32'hAC22_0004;
    localparam logic [31:0] I_J    = 32'h0800_0003;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_BLTZ = 32'h0420_0005;
    localparam logic [31:0] I_ILL  = 32'hFC00_0000;
    localparam logic [31:0] I_X    = 32'hFFFF_FFFF;

    localparam logic [10:0] IRL = 11'h400;
    localparam logic [10:0] PCE = 11'h200;
    localparam logic [10:0] BR  = 11'h100;
    localparam logic [10:0] JMP = 11'h080;
    localparam logic [10:0] JR  = 11'h040;
    localparam logic [10:0] RW  = 11'h020;
    localparam logic [10:0] RD  = 11'h010;
    localparam logic [10:0] AS  = 11'h008;
    localparam logic [10:0] M2R = 11'h004;
    localparam logic [10:0] MR  = 11'h002;
    localparam logic [10:0] MW  = 11'h001;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          mem_ready;
    logic          ir_load, pc_en, branch, jump, jump_reg;
    logic          reg_write, reg_dst, alu_src, mem_to_reg;
    logic [2:0]    alu_op;
    logic          mem_read, mem_write, illegal;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]   instr;
        logic          rdy;
        logic [2:0]    st;
        logic [10:0]   ctl;
        logic [2:0]    aop;
        logic [CW-1:0] ret;
        logic          ill;
    } vec_t;

    vec_t vecs[$];

    multi_cycle_controller #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .ir_load    (ir_load),
        .pc_en      (pc_en),
        .branch     (branch),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .illegal    (illegal),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] act_vec();
        return {10'd0, state, ir_load, pc_en, branch, jump, jump_reg, reg_write, reg_dst,
                alu_src, mem_to_reg, mem_read, mem_write, alu_op, retired, illegal};
    endfunction

    function automatic logic [31:0] exp_vec(input logic [2:0] st, input logic [10:0] ctl,
                                            input logic [2:0] aop, input logic [CW-1:0] ret,
                                            input logic ill);
        return {10'd0, st, ctl, aop, ret, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] i, input logic r, input logic [2:0] s,
                       input logic [10:0] c, input logic [2:0] a, input int ret,
                       input logic ill);
        vec_t v;
        v.instr = i;
        v.rdy   = r;
        v.st    = s;
        v.ctl   = c;
        v.aop   = a;
        v.ret   = CW'(ret);
        v.ill   = ill;
        vecs.push_back(v);
    endtask

    initial begin
        // Live instr is garbage (I_X) outside FETCH: decode must use the captured copy.
        add(I_ADD, 0, 0, IRL, 0, 0, 0);
        add(I_X,   1, 1, 0,   0, 0, 0);
        add(I_X,   1, 2, RD,  0, 0, 0);
        add(I_X,   0, 4, RW | RD | PCE, 0, 0, 0);
        add(I_SUB, 1, 0, IRL, 0, 1, 0);
        add(I_X,   0, 1, 0,   0, 1, 0);
        add(I_X,   0, 2, RD,  1, 1, 0);
        add(I_X,   1, 4, RW | RD | PCE, 0, 1, 0);
        add(I_SLT, 0, 0, IRL, 0, 2, 0);
        add(I_X,   1, 1, 0,   0, 2, 0);
        add(I_X,   1, 2, RD,  2, 2, 0);
        add(I_X,   0, 4, RW | RD | PCE, 0, 2, 0);
        // lw with three wait cycles: 8 cycles total.
        add(I_LW,  1, 0, IRL, 0, 3, 0);
        add(I_X,   1, 1, 0,   0, 3, 0);
        add(I_X,   1, 2, AS,  0, 3, 0);
        add(I_X,   0, 3, AS | MR, 0, 3, 0);
        add(I_X,   0, 3, AS | MR, 0, 3, 0);
        add(I_X,   0, 3, AS | MR, 0, 3, 0);
        add(I_X,   1, 3, AS | MR, 0, 3, 0);
        add(I_X,   0, 4, RW | M2R | PCE, 0, 3, 0);
        // sw ready on first MEM cycle.
        add(I_SW,  0, 0, IRL, 0, 4, 0);
        add(I_X,   1, 1, 0,   0, 4, 0);
        add(I_X,   1, 2, AS,  0, 4, 0);
        add(I_X,   1, 3, AS | MW | PCE, 0, 4, 0);
        add(I_J,   1, 0, IRL, 0, 5, 0);
        add(I_X,   1, 1, JMP | PCE, 0, 5, 0);
        add(I_JR,  0, 0, IRL, 0, 6, 0);
        add(I_X,   0, 1, JR | PCE, 0, 6, 0);
        add(I_BLTZ, 1, 0, IRL, 0, 7, 0);
        add(I_X,   0, 1, BR | PCE, 0, 7, 0);
        add(I_ILL, 0, 0, IRL, 0, 8, 0);
`ifdef MCC_ILLEGAL_TRAP_EN
        add(I_X,   1, 1, 0, 0, 8, 0);
        add(I_X,   1, 5, 0, 0, 8, 1);
        add(I_X,   0, 5, 0, 0, 8, 1);
        add(I_X,   1, 5, 0, 0, 8, 1);
`else
        add(I_X,   1, 1, PCE, 0, 8, 0);
        add(I_ILL, 1, 0, IRL, 0, 9, 0);
`endif

        reset     = 1'b0;
        instr     = 32'h0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", act_vec(), exp_vec(3'd0, IRL, 3'd0, '0, 1'b0));
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            instr     = vecs[i].instr;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", i), act_vec(),
                  exp_vec(vecs[i].st, vecs[i].ctl, vecs[i].aop, vecs[i].ret, vecs[i].ill));
            @(posedge clk);
            #1;
        end

        // Abort an lw during its MEM wait with an asynchronous reset.
        reset = 1'b0;
        #2;
        check("reset_clear", act_vec(), exp_vec(3'd0, IRL, 3'd0, '0, 1'b0));
        reset     = 1'b1;
        instr     = I_J;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        instr = I_X;
        @(posedge clk);
        #1;
        instr = I_LW;
        repeat (3) @(posedge clk);
        #1;
        instr = I_X;
        @(negedge clk);
        check("lw_wait", {25'd0, state, mem_read, retired}, {25'd0, 3'd3, 1'b1, 4'd1});
        #2;
        reset = 1'b0;
        #1;
        check("reset_abort", act_vec(), exp_vec(3'd0, IRL, 3'd0, '0, 1'b0));
        @(posedge clk);
        #1;
        check("reset_hold", act_vec(), exp_vec(3'd0, IRL, 3'd0, '0, 1'b0));
        reset = 1'b1;

        // retired wraps from all-ones to zero.
        instr     = I_J;
        mem_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("cnt_15", {25'd0, state, retired}, {25'd0, 3'd0, 4'd15});
        repeat (2) @(posedge clk);
        #1;
        check("cnt_wrap", {25'd0, state, retired}, {25'd0, 3'd0, 4'd0});
        repeat (2) @(posedge clk);
        #1;
        check("cnt_after_wrap", {25'd0, state, retired}, {25'd0, 3'd0, 4'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
